spi_status_tx: RTL and testbench



---
 rtl/spi_status_tx.sv | 128 ++++++++++++
 tb/tb_spi_status_tx.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_status_tx.sv
// spi_status_tx: queues 16-bit status words {code,data} and shifts them MSB-first on sdo in cs-low frames.
// Latency: a word pushed on edge N is the head from edge N+1; sdo is combinational from cs/bit_cnt/head.
// Backpressure: none toward the fabric; a push into a full FIFO is dropped and sets sticky overflow.
// Build option SPI_STATUS_REPLAY_EN: pop on frame completion so an aborted frame is retransmitted.
module spi_status_tx #(
    parameter int DEPTH   = 4,
    parameter int FRAME_W = 16
) (
    input  logic                     sclk,
    input  logic                     reset,
    input  logic                     cs,
    input  logic                     evt_valid,
    input  logic [3:0]               evt_code,
    input  logic [11:0]              evt_data,
    output logic                     sdo,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     frame_done
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [FRAME_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] tx_word;
    logic [3:0]         bit_cnt;
    logic               empty;
    logic               full;
    logic               load;
    logic               pop;
    logic               push_req;
    logic               push;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign load       = !cs && (bit_cnt == 4'd0);
    assign tx_word    = empty ? '0 : mem[rd_ptr];
    assign push_req   = evt_valid && (evt_code != 4'd0);
    // A same-edge pop frees the slot, so a push into a full FIFO still lands.
    assign push       = push_req && (!full || pop);
    assign fifo_count = count;

`ifdef SPI_STATUS_REPLAY_EN
    // Whether the frame being shifted carries a queued word (vs a NOP), captured at frame start.
    logic real_frame;

    // Latch frame type at the load edge; the head is only released once the frame completes.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            real_frame <= 1'b0;
        end else if (load) begin
            real_frame <= !empty;
        end
    end

    assign pop = !cs && (bit_cnt == 4'd15) && real_frame;
`else
    // Head leaves the FIFO as soon as it is loaded; an abort therefore loses it.
    assign pop = load && !empty;
`endif

    // Storage array: no reset needed, validity is tracked by count.
    always_ff @(posedge sclk) begin
        if (push) begin
            mem[wr_ptr] <= {evt_code, evt_data};
        end
    end

    // FIFO pointers, occupancy and sticky drop flag.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (push && !pop) begin
                count <= count + CNT_ONE;
            end else if (pop && !push) begin
                count <= count - CNT_ONE;
            end
            if (push_req && !push) begin
                overflow <= 1'b1;
            end
        end
    end

    // Frame sequencing: cs high parks at frame start; 4-bit counter wraps for back-to-back frames.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            bit_cnt    <= 4'd0;
            shreg      <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= !cs && (bit_cnt == 4'd15);
            if (cs) begin
                bit_cnt <= 4'd0;
            end else if (load) begin
                shreg   <= {tx_word[FRAME_W-2:0], 1'b0};
                bit_cnt <= 4'd1;
            end else begin
                shreg   <= {shreg[FRAME_W-2:0], 1'b0};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    // MSB goes straight from the head at frame start, then from the shift register.
    always_comb begin
        sdo = 1'b0;
        if (!cs) begin
            sdo = (bit_cnt == 4'd0) ? tx_word[FRAME_W-1] : shreg[FRAME_W-1];
        end
    end

endmodule

// File: tb/tb_spi_status_tx.sv
// tb_spi_status_tx: table-driven, directed and random checks of spi_status_tx against a queue-based model.
// Inputs change just after the falling edge; outputs are compared 1 ns later, as the MCU would sample.
// Honours SPI_STATUS_REPLAY_EN to select the expected pop/abort behaviour.
module tb_spi_status_tx;

    localparam int DEPTH = 4;

    logic        sclk;
    logic        reset;
    logic        cs;
    logic        evt_valid;
    logic [3:0]  evt_code;
    logic [11:0] evt_data;
    logic        sdo;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        frame_done;

    spi_status_tx #(.DEPTH(DEPTH), .FRAME_W(16)) dut (
        .sclk       (sclk),
        .reset      (reset),
        .cs         (cs),
        .evt_valid  (evt_valid),
        .evt_code   (evt_code),
        .evt_data   (evt_data),
        .sdo        (sdo),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int nvec = 0;
    int nerr = 0;

    // Reference model: queue of words, position inside the current frame, frame word snapshot.
    logic [15:0] q[$];
    int          pos;
    logic [15:0] cur_word;
    bit          cur_real;
    bit          ovf_m;
    bit          fd_m;

    logic [31:0] rx;
    int          fd_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        pos = 0; cur_word = 16'h0; cur_real = 0; ovf_m = 0; fd_m = 0;
    endtask

    function automatic logic exp_sdo(input logic c);
        if (c) return 1'b0;
        if (pos == 0) return (q.size() != 0) ? q[0][15] : 1'b0;
        return cur_word[15-pos];
    endfunction

    task automatic model_update(input logic c, input logic v, input logic [3:0] cd, input logic [11:0] d);
        bit pop = 0;
        bit fd_n = 0;
        if (c) begin
            pos = 0;
        end else begin
            if (pos == 0) begin
                cur_real = (q.size() != 0);
                cur_word = cur_real ? q[0] : 16'h0;
`ifndef SPI_STATUS_REPLAY_EN
                pop = cur_real;
`endif
            end
            pos++;
            if (pos == 16) begin
                pos = 0;
                fd_n = 1;
`ifdef SPI_STATUS_REPLAY_EN
                pop = cur_real;
`endif
            end
        end
        if (v && cd != 4'd0 && !(q.size() < DEPTH || pop)) ovf_m = 1;
        if (pop) void'(q.pop_front());
        if (v && cd != 4'd0 && q.size() < DEPTH) q.push_back({cd, d});
        fd_m = fd_n;
    endtask

    // One SPI clock: drive, compare against model, sample sdo like the MCU, then clock the model.
    task automatic step(input logic c, input logic v, input logic [3:0] cd, input logic [11:0] d);
        cs = c; evt_valid = v; evt_code = cd; evt_data = d;
        #1;
        chk("sdo", {31'b0, sdo}, {31'b0, exp_sdo(c)});
        chk("fifo_count", {29'b0, fifo_count}, q.size());
        chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
        chk("frame_done", {31'b0, frame_done}, {31'b0, fd_m});
        if (frame_done) fd_cnt++;
        if (!c) rx = {rx[30:0], sdo};
        @(posedge sclk);
        model_update(c, v, cd, d);
        @(negedge sclk);
    endtask

    task automatic push(input logic [15:0] w);
        step(1'b1, 1'b1, w[15:12], w[11:0]);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b1, 1'b0, 4'h0, 12'h0);
    endtask

    // n frames with cs held low, then one idle clock so the last frame_done pulse is observed.
    task automatic run_frames(input int n);
        rx = 0; fd_cnt = 0;
        repeat (16 * n) step(1'b0, 1'b0, 4'h0, 12'h0);
        step(1'b1, 1'b0, 4'h0, 12'h0);
    endtask

    task automatic do_reset();
        reset = 1'b0; cs = 1'b1; evt_valid = 1'b0; evt_code = 4'h0; evt_data = 12'h0;
        model_reset();
        @(negedge sclk);
        @(negedge sclk);
        reset = 1'b1;
    endtask

    typedef struct {
        logic [3:0]  code;
        logic [11:0] data;
        logic [15:0] exp_word;
        logic [2:0]  exp_cnt_before;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{4'h1, 12'h2A5, 16'h12A5, 3'd1};
        tbl[1] = '{4'h2, 12'h001, 16'h2001, 3'd1};
        tbl[2] = '{4'h3, 12'hFFF, 16'h3FFF, 3'd1};
        tbl[3] = '{4'h0, 12'h123, 16'h0000, 3'd0};
        tbl[4] = '{4'hF, 12'h000, 16'hF000, 3'd1};
        tbl[5] = '{4'h8, 12'h555, 16'h8555, 3'd1};

        rx = 0; fd_cnt = 0;
        do_reset();
        #1;
        chk("reset_sdo", {31'b0, sdo}, 32'd0);
        chk("reset_count", {29'b0, fifo_count}, 32'd0);
        chk("reset_overflow", {31'b0, overflow}, 32'd0);
        chk("reset_frame_done", {31'b0, frame_done}, 32'd0);
        @(negedge sclk);

        // Empty transaction gives a NOP frame.
        run_frames(1);
        chk("empty_frame", rx[15:0], 32'h0000);
        chk("empty_fd", fd_cnt, 1);

        // Single-word table.
        for (int i = 0; i < 6; i++) begin
            push({tbl[i].code, tbl[i].data});
            chk("tbl_count_before", {29'b0, fifo_count}, {29'b0, tbl[i].exp_cnt_before});
            run_frames(1);
            chk("tbl_word", rx[15:0], {16'b0, tbl[i].exp_word});
            chk("tbl_count_after", {29'b0, fifo_count}, 32'd0);
            chk("tbl_fd", fd_cnt, 1);
        end

        // Back-to-back frames without cs deassertion.
        push(16'h2001);
        push(16'h3FFF);
        run_frames(2);
        chk("b2b_words", rx, 32'h2001_3FFF);
        chk("b2b_fd", fd_cnt, 2);

        // Overflow: fifth word dropped, first four come out in order.
        push(16'h1111); push(16'h2222); push(16'h3333); push(16'h4444); push(16'h5555);
        chk("ovf_count", {29'b0, fifo_count}, 32'd4);
        chk("ovf_flag", {31'b0, overflow}, 32'd1);
        run_frames(2);
        chk("ovf_words01", rx, 32'h1111_2222);
        run_frames(2);
        chk("ovf_words23", rx, 32'h3333_4444);
        run_frames(1);
        chk("ovf_drained", rx[15:0], 32'h0000);
        chk("ovf_sticky", {31'b0, overflow}, 32'd1);

        // Abort after 7 bits, then a full frame.
        do_reset();
        push(16'h1123);
        repeat (7) step(1'b0, 1'b0, 4'h0, 12'h0);
        step(1'b1, 1'b0, 4'h0, 12'h0);
        chk("abort_no_fd", {31'b0, frame_done}, 32'd0);
        run_frames(1);
`ifdef SPI_STATUS_REPLAY_EN
        chk("abort_retx", rx[15:0], 32'h1123);
`else
        chk("abort_lost", rx[15:0], 32'h0000);
`endif
        chk("abort_fd", fd_cnt, 1);

        // Push while full on the same edge as a pop is accepted.
        push(16'hA001); push(16'hA002); push(16'hA003); push(16'hA004);
`ifdef SPI_STATUS_REPLAY_EN
        repeat (15) step(1'b0, 1'b0, 4'h0, 12'h0);
        step(1'b0, 1'b1, 4'hA, 12'h005);
`else
        step(1'b0, 1'b1, 4'hA, 12'h005);
        repeat (15) step(1'b0, 1'b0, 4'h0, 12'h0);
`endif
        chk("full_pop_push_ovf", {31'b0, overflow}, 32'd0);
        chk("full_pop_push_cnt", {29'b0, fifo_count}, 32'd4);
        run_frames(4);
        chk("full_pop_push_tail", rx[15:0], 32'hA005);

        // Randomized traffic with occasional cs gaps; the model checks every clock.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int rate;
            rate = (i < 1500) ? 2 : 30;
            step(($urandom_range(0, 19) == 0), ($urandom_range(0, rate) == 0),
                 4'($urandom_range(0, 15)), 12'($urandom));
        end

        // Asynchronous reset in the middle of bit 9.
        do_reset();
        push(16'h7001); push(16'h7002); push(16'h7003); push(16'h7004); push(16'h7005);
        repeat (9) step(1'b0, 1'b0, 4'h0, 12'h0);
        cs = 1'b0;
        #2;
        chk("pre_reset_overflow", {31'b0, overflow}, 32'd1);
        reset = 1'b0;
        #1;
        chk("midreset_count", {29'b0, fifo_count}, 32'd0);
        chk("midreset_sdo", {31'b0, sdo}, 32'd0);
        chk("midreset_overflow", {31'b0, overflow}, 32'd0);
        chk("midreset_fd", {31'b0, frame_done}, 32'd0);
        model_reset();
        @(negedge sclk);
        reset = 1'b1;
        run_frames(1);
        chk("post_reset_frame", rx[15:0], 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
